uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Downstream consumer of the rv32 core's UART write port. It accepts bytes through a valid/ready handshake, buffers them in a small FIFO and serialises them as 8N1 frames on a single TX line. It replaces the tie-off that assumes the UART is always ready. Real backpressure reaches the core through ext_uart_write_out.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); must be >= 2
FIFO_DEPTH, 8, byte entries; power of two, >= 2

Ports:
CLK  input  1  sole clock, rising edge
RST  input  1  reset; one clock; reset is synchronous and active-high
wr_valid  input  1  core presents a byte (ext_uart_write_arg[8])
wr_data  input  8  byte to send (ext_uart_write_arg[7:0])
wr_ready  output  1  FIFO can accept; drives ext_uart_write_out
tx  output  1  serial line; idle high
busy  output  1  FIFO non-empty or frame in progress
level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset values (cycle after RST is sampled high): tx=1, wr_ready=1, busy=0, level=0, FSM=IDLE, all counters 0, FIFO pointers 0.
- Push: a byte is accepted on an edge where wr_valid && wr_ready. wr_ready = (level != FIFO_DEPTH), computed from registered state only, with no combinational path from wr_valid.
- At full, wr_ready=0 even if a pop occurs in the same cycle. wr_ready returns 1 in the cycle after the pop.
- Same-edge push and pop at 0 < level < DEPTH: level is unchanged, and the data order is preserved.
- Pointers wrap modulo FIFO_DEPTH. level is a separate counter, so there is no full/empty ambiguity.
- tx is a registered output with no glitches.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. If level != 0, pop the head into shift_reg, load the baud counter with CLKS_PER_BIT-1, and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then bit_idx=0 and go to DATA.
- DATA: tx = shift_reg[0], LSB first. On each baud expiry, shift right and increment bit_idx. After the bit_idx==7 period, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On expiry, if level != 0, pop and go straight to START with no idle cycle; otherwise go to IDLE.
- Baud counter counts down from CLKS_PER_BIT-1 to 0 and reloads on expiry. Width is $clog2(CLKS_PER_BIT).
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames have a period of exactly 10*CLKS_PER_BIT.
- Latency: a byte accepted at edge t into an empty FIFO while IDLE is popped at edge t+1. tx goes low after edge t+1.
- busy = (state != IDLE) || (level != 0), registered-equivalent.
- Reset mid-frame: the current frame is aborted and tx returns to 1 the cycle after reset. The FIFO is flushed and queued bytes are discarded. No partial frame is resumed.
- Data present with wr_valid=0 is ignored. wr_data is don't-care when wr_valid=0.

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, STOP}
  - UART_FRAME_BITS = 10
  - default CLKS_PER_BIT constants for 100 MHz/115200 and 25 MHz/115200
- Sub-module uart_byte_fifo (sync FIFO: push/pop/level, DEPTH param, same CLK/RST) is instantiated once.
- The serialiser FSM lives in uart_tx_fifo.

Test Plan:
1. Reset: hold RST 3 cycles with wr_valid=1 -> tx=1, wr_ready=1, busy=0, level=0, and no byte accepted.
2. CLKS_PER_BIT=4, single push 0x55 at edge t:
   - tx=0 after edge t+1 for 4 cycles.
   - Then bits 1,0,1,0,1,0,1,0, 4 cycles each.
   - Then stop=1 for 4 cycles.
   - busy drops after edge t+41.
3. Push 0x00 then 0xFF back-to-back:
   - Frames are contiguous (second start bit immediately follows first stop bit).
   - Waveform is 0 x9 periods, 1, 0, 1 x9 periods.
4. Backpressure: hold wr_valid=1 streaming 0x01..0x0C:
   - level peaks at 8 and wr_ready=0 while full.
   - wr_ready returns 1 the cycle after each pop.
   - Decoded output is 0x01..0x0C in order, with no loss or duplication.
5. Same-edge push and pop at level=3 -> level stays 3, and the pushed byte appears 3 frames later.
6. Reset mid-frame: assert RST during DATA bit 3 with level=2 -> tx=1, level=0, busy=0 next cycle; after release, with no further pushes, tx stays 1 for 50 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int UART_FRAME_BITS = 10;

  // Clock cycles per bit at 115200 baud for the two common system clocks
  localparam int CLKS_PER_BIT_100M_115200 = 868;
  localparam int CLKS_PER_BIT_25M_115200  = 217;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with an explicit occupancy counter and a combinational head read.
module uart_byte_fifo #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       head,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [7:0]       mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [LVL_W-1:0] level_next;
  logic             push_en;
  logic             pop_en;

  assign full    = (level_reg == LVL_W'(DEPTH));
  assign empty   = (level_reg == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];
  assign level   = level_reg;

  always_comb begin
    level_next = level_reg;
    case ({push_en, pop_en})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push_en) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg <= level_next;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, FIFO, registered serial output.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = CLKS_PER_BIT_100M_115200,
  parameter  int FIFO_DEPTH   = 8,
  localparam int LVL_W        = $clog2(FIFO_DEPTH + 1),
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic             tx,
  output logic             busy,
  output logic [LVL_W-1:0] level
);

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]        bit_idx_reg, bit_idx_next;
  logic [7:0]        shift_reg, shift_next;
  logic              tx_reg, tx_next;
  logic              fifo_pop;
  logic [7:0]        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle
  assign wr_ready = !fifo_full;
  assign busy     = (state_reg != IDLE) || !fifo_empty;
  assign tx       = tx_reg;

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    fifo_pop     = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_head;
          baud_next  = BAUD_RELOAD;
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (baud_reg == '0) begin
          baud_next    = BAUD_RELOAD;
          bit_idx_next = 3'd0;
          state_next   = DATA;
          tx_next      = shift_reg[0];
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_reg == '0) begin
          baud_next = BAUD_RELOAD;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_reg == '0) begin
          // Chain straight into the next start bit so queued frames stay contiguous
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_head;
            baud_next  = BAUD_RELOAD;
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a serial decoder pops expected bytes, tasks check waveforms and flow control.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_valid = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_ready;
  logic             tx;
  logic             busy;
  logic [LVL_W-1:0] level;

  int         total = 0;
  int         bad = 0;
  logic [7:0] q[$];
  bit         mon_en = 1'b1;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK      (clk),
    .RST      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .tx       (tx),
    .busy     (busy),
    .level    (level)
  );

  // Ideal line level k cycles after the pop edge of a frame carrying b (k = 1..40)
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int seg;
    seg = (k - 1) / CPB;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return b[seg-1];
    return 1'b1;
  endfunction

  // Serial decoder: samples mid-bit and checks each frame against the scoreboard
  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat ((i == 0) ? CPB + CPB / 2 : CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        total++;
        if (tx !== 1'b1) begin
          bad++;
          $display("FAIL stop_bit: tx=%b required 1", tx);
        end
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_frame: got %02h required no frame", b);
        end else begin
          e = q.pop_front();
          if (b !== e) begin
            bad++;
            $display("FAIL frame_data: got %02h required %02h", b, e);
          end else begin
            $display("frame ok: %02h", b);
          end
        end
        repeat (CPB - CPB / 2 - 1) @(negedge clk);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leaves wr_valid high after the accepting edge so consecutive calls stream
  task automatic push_byte(input logic [7:0] d, input bit track);
    int n;
    n = 0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = d;
    while (wr_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (wr_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL push_timeout: wr_ready=%b required 1", wr_ready);
    end else begin
      @(posedge clk);
      if (track) q.push_back(d);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((busy !== 1'b0 || q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0 || q.size() != 0) begin
      bad++;
      $display("FAIL drain: busy=%b pending=%0d required 0 and 0", busy, q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || wr_ready !== 1'b1 || busy !== 1'b0 || level !== '0) begin
      bad++;
      $display("FAIL reset_state: tx=%b rdy=%b busy=%b level=%0d required 1 1 0 0", tx, wr_ready, busy, level);
    end
    rst      = 1'b0;
    wr_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || level !== '0) begin
        bad++;
        $display("FAIL reset_no_accept: tx=%b busy=%b level=%0d required 1 0 0", tx, busy, level);
      end
    end
    $display("test_reset complete");
  endtask

  task automatic test_single_frame();
    push_byte(8'h55, 1'b1);
    @(negedge clk);
    wr_valid = 1'b0;
    total++;
    if (tx !== 1'b1 || level !== LVL_W'(1)) begin
      bad++;
      $display("FAIL single_accept: tx=%b level=%0d required 1 1", tx, level);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      total++;
      if (tx !== exp_tx(8'h55, k)) begin
        bad++;
        $display("FAIL single_wave k=%0d: tx=%b required %b", k, tx, exp_tx(8'h55, k));
      end
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL single_busy_hold: busy=%b required 1", busy);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_busy_drop: busy=%b required 0", busy);
    end
    wait_drain();
    $display("test_single_frame complete");
  endtask

  task automatic test_back_to_back();
    int         frame;
    logic [7:0] b;
    push_byte(8'h00, 1'b1);
    push_byte(8'hFF, 1'b1);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      wr_valid = 1'b0;
      frame = (k - 1) / 40;
      b = (frame == 0) ? 8'h00 : 8'hFF;
      total++;
      if (tx !== exp_tx(b, k - 40 * frame)) begin
        bad++;
        $display("FAIL b2b_wave k=%0d: tx=%b required %b", k, tx, exp_tx(b, k - 40 * frame));
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_busy_drop: busy=%b required 0", busy);
    end
    wait_drain();
    $display("test_back_to_back complete");
  endtask

  task automatic test_backpressure();
    bit   done;
    int   peak;
    logic exp_rdy;
    done = 1'b0;
    peak = 0;
    fork
      begin
        for (int i = 1; i <= 12; i++) push_byte(8'(i), 1'b1);
        @(negedge clk);
        wr_valid = 1'b0;
        done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!done && n < 2000) begin
          @(negedge clk);
          n++;
          if (int'(level) > peak) peak = int'(level);
          exp_rdy = (level != LVL_W'(DEPTH));
          total++;
          if (wr_ready !== exp_rdy) begin
            bad++;
            $display("FAIL bp_ready level=%0d: wr_ready=%b required %b", level, wr_ready, exp_rdy);
          end
        end
      end
    join
    total++;
    if (peak != DEPTH) begin
      bad++;
      $display("FAIL bp_peak: peak=%0d required %0d", peak, DEPTH);
    end
    wait_drain();
    $display("test_backpressure complete");
  endtask

  task automatic test_same_edge();
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    push_byte(8'h44, 1'b1);
    @(negedge clk);
    wr_valid = 1'b0;
    total++;
    if (level !== LVL_W'(3)) begin
      bad++;
      $display("FAIL same_pre_level: level=%0d required 3", level);
    end
    repeat (37) @(negedge clk);
    total++;
    if (level !== LVL_W'(3) || tx !== 1'b1) begin
      bad++;
      $display("FAIL same_before: level=%0d tx=%b required 3 1", level, tx);
    end
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    @(posedge clk);
    q.push_back(8'h99);
    @(negedge clk);
    wr_valid = 1'b0;
    total++;
    if (level !== LVL_W'(3) || tx !== 1'b0) begin
      bad++;
      $display("FAIL same_after: level=%0d tx=%b required 3 0", level, tx);
    end
    wait_drain();
    $display("test_same_edge complete");
  endtask

  task automatic test_reset_mid_frame();
    mon_en = 1'b0;
    push_byte(8'h3C, 1'b0);
    push_byte(8'hC3, 1'b0);
    push_byte(8'h5A, 1'b0);
    @(negedge clk);
    wr_valid = 1'b0;
    total++;
    if (level !== LVL_W'(2)) begin
      bad++;
      $display("FAIL mid_level: level=%0d required 2", level);
    end
    repeat (16) @(negedge clk);
    total++;
    if (tx !== exp_tx(8'h3C, 18)) begin
      bad++;
      $display("FAIL mid_bit3: tx=%b required %b", tx, exp_tx(8'h3C, 18));
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || level !== '0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset: tx=%b level=%0d busy=%b rdy=%b required 1 0 0 1", tx, level, busy, wr_ready);
    end
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL mid_quiet c=%0d: tx=%b busy=%b required 1 0", c, tx, busy);
      end
    end
    mon_en = 1'b1;
    $display("test_reset_mid_frame complete");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_same_edge();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
